// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed 7-segment driver.
// Segment vectors are {g,f,e,d,c,b,a}, with segment a (the top bar) in bit 0.
package seg7_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_G = 6;

    typedef logic [SEG_G:SEG_A] seg_t;

    localparam seg_t GLYPH_0   = 7'h3F;
    localparam seg_t GLYPH_1   = 7'h06;
    localparam seg_t GLYPH_2   = 7'h5B;
    localparam seg_t GLYPH_3   = 7'h4F;
    localparam seg_t GLYPH_4   = 7'h66;
    localparam seg_t GLYPH_5   = 7'h6D;
    localparam seg_t GLYPH_6   = 7'h7D;
    localparam seg_t GLYPH_7   = 7'h07;
    localparam seg_t GLYPH_8   = 7'h7F;
    localparam seg_t GLYPH_9   = 7'h6F;
    localparam seg_t GLYPH_A   = 7'h77;
    localparam seg_t GLYPH_B   = 7'h7C;
    localparam seg_t GLYPH_C   = 7'h39;
    localparam seg_t GLYPH_D   = 7'h5E;
    localparam seg_t GLYPH_E   = 7'h79;
    localparam seg_t GLYPH_F   = 7'h71;
    localparam seg_t SEG_BLANK = 7'h00;

    // Display mode bits that travel with the value through pending/committed.
    typedef struct packed {
        logic hex_mode;
        logic blank_lz;
    } disp_mode_t;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Host-side update bus of the scan driver: value/mode capture strobe and live brightness.
// The core drives it through master; the display driver samples it through slave.
interface seg7_scan_driver_if #(
    parameter int DIGITS = 4
);

    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp_in;
    logic                  hex_mode;
    logic                  blank_lz;
    logic [3:0]            brightness;

    modport master (
        output load,
        output value,
        output dp_in,
        output hex_mode,
        output blank_lz,
        output brightness
    );

    modport slave (
        input  load,
        input  value,
        input  dp_in,
        input  hex_mode,
        input  blank_lz,
        input  brightness
    );

endinterface

// File: rtl/seg7_glyph.sv
// Nibble to active-high segment pattern; decimal mode blanks nibbles above 9.
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_mode,
    output seg_t       pattern
);

    // NOTE: default assigned first so no path through this block can infer a latch.
    always_comb begin
        pattern = SEG_BLANK;
        unique case (nibble)
            4'h0: pattern = GLYPH_0;
            4'h1: pattern = GLYPH_1;
            4'h2: pattern = GLYPH_2;
            4'h3: pattern = GLYPH_3;
            4'h4: pattern = GLYPH_4;
            4'h5: pattern = GLYPH_5;
            4'h6: pattern = GLYPH_6;
            4'h7: pattern = GLYPH_7;
            4'h8: pattern = GLYPH_8;
            4'h9: pattern = GLYPH_9;
            4'hA: pattern = GLYPH_A;
            4'hB: pattern = GLYPH_B;
            4'hC: pattern = GLYPH_C;
            4'hD: pattern = GLYPH_D;
            4'hE: pattern = GLYPH_E;
            4'hF: pattern = GLYPH_F;
            default: pattern = SEG_BLANK;
        endcase
        if (!hex_mode && nibble > 4'd9) begin
            pattern = SEG_BLANK;
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-sliced N-digit 7-segment driver with tear-free frame commit, leading-zero
// blanking, per-digit decimal point, PWM brightness and registered pin outputs.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 1024,
    parameter bit COMMON_ANODE = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seg7_scan_driver_if.slave    host,
    output seg_t                 segments,
    output logic                 dp,
    output logic [DIGITS-1:0]    digit_en,
    output logic                 frame_pulse
);

    localparam int SLOT_W  = $clog2(SCAN_DIV);
    localparam int DIGIT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
    localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(DIGITS - 1);

    // XOR masks that turn the internal active-high levels into pin polarity.
    localparam seg_t              SEG_INV = {7{COMMON_ANODE}};
    localparam logic [DIGITS-1:0] EN_INV  = {DIGITS{COMMON_ANODE}};

    logic [SLOT_W-1:0]   slot_cnt;
    logic [DIGIT_W-1:0]  digit_idx;
    logic                slot_wrap;
    logic                frame_end;

    logic [4*DIGITS-1:0] pend_value;
    logic [DIGITS-1:0]   pend_dp;
    disp_mode_t          pend_mode;
    logic [4*DIGITS-1:0] disp_value;
    logic [DIGITS-1:0]   disp_dp;
    disp_mode_t          disp_mode;
    disp_mode_t          in_mode;

    logic [3:0]          act_nibble;
    logic                act_dp;
    logic                upper_zero;
    logic                lz_blank;
    seg_t                act_glyph;

    logic                guard;
    logic                pwm_on;
    logic                lit;
    seg_t                seg_nxt;
    logic                dp_nxt;
    logic [DIGITS-1:0]   en_nxt;

    assign slot_wrap = (slot_cnt == SLOT_LAST);
    assign frame_end = slot_wrap && (digit_idx == DIGIT_LAST);
    assign in_mode   = '{hex_mode: host.hex_mode, blank_lz: host.blank_lz};

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
        end else begin
            slot_cnt <= slot_cnt + SLOT_W'(1);
            if (slot_wrap) begin
                digit_idx <= (digit_idx == DIGIT_LAST) ? '0 : digit_idx + DIGIT_W'(1);
            end
        end
    end

    // A load on the commit cycle itself goes straight to the committed copy.
    // NOTE: the display state registers are reset too, so a fresh frame shows 0, not stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_value <= '0;
            pend_dp    <= '0;
            pend_mode  <= '0;
            disp_value <= '0;
            disp_dp    <= '0;
            disp_mode  <= '0;
        end else begin
            if (host.load) begin
                pend_value <= host.value;
                pend_dp    <= host.dp_in;
                pend_mode  <= in_mode;
            end
            if (frame_end) begin
                disp_value <= host.load ? host.value : pend_value;
                disp_dp    <= host.load ? host.dp_in : pend_dp;
                disp_mode  <= host.load ? in_mode : pend_mode;
            end
        end
    end

    // Walk from the most significant digit down so upper_zero covers digits i..DIGITS-1.
    always_comb begin
        act_nibble = 4'd0;
        act_dp     = 1'b0;
        lz_blank   = 1'b0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (disp_value[4*i +: 4] == 4'd0);
            if (digit_idx == DIGIT_W'(i)) begin
                act_nibble = disp_value[4*i +: 4];
                act_dp     = disp_dp[i];
                lz_blank   = disp_mode.blank_lz && upper_zero && (i != 0);
            end
        end
    end

    seg7_glyph u_glyph (
        .nibble   (act_nibble),
        .hex_mode (disp_mode.hex_mode),
        .pattern  (act_glyph)
    );

    // Slot 0 of every digit is dark so the previous digit's segments never ghost onto the next.
    assign guard  = (slot_cnt == '0);
    assign pwm_on = (slot_cnt[SLOT_W-1 -: 4] <= host.brightness);
    assign lit    = pwm_on && !guard;

    always_comb begin
        seg_nxt = SEG_BLANK;
        dp_nxt  = 1'b0;
        en_nxt  = '0;
        if (lit) begin
            seg_nxt = lz_blank ? SEG_BLANK : act_glyph;
            dp_nxt  = act_dp;
            en_nxt  = DIGITS'(1) << digit_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            segments    <= SEG_INV;
            dp          <= COMMON_ANODE;
            digit_en    <= EN_INV;
            frame_pulse <= 1'b0;
        end else begin
            segments    <= seg_nxt ^ SEG_INV;
            dp          <= dp_nxt ^ COMMON_ANODE;
            digit_en    <= en_nxt ^ EN_INV;
            frame_pulse <= guard && (digit_idx == '0);
        end
    end

endmodule
